// File: rtl/hart_regfile.sv
// Per-hart banked integer register file with a pending-write scoreboard.
// Writeback port updates data and clears busy; decode issue sets busy; reads are combinational with bypass.
module hart_regfile #(
   parameter  int NHARTS = 4,
   parameter  int XLEN   = 32,
   parameter  int NREGS  = 32,
   localparam int HW     = $clog2(NHARTS),
   localparam int AW     = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            RegWrite_ee,
   input  logic [AW-1:0]   Waddr_ee,
   input  logic [XLEN-1:0] Wdata_ee,
   input  logic [HW-1:0]   mhartID_ee,
   input  logic [HW-1:0]   mhartID_ID,
   input  logic [AW-1:0]   Raddr1_ID,
   input  logic [AW-1:0]   Raddr2_ID,
   output logic [XLEN-1:0] Rdata1_ID,
   output logic [XLEN-1:0] Rdata2_ID,
   input  logic            IssueWr_ID,
   input  logic [AW-1:0]   Waddr_ID,
   output logic            Busy1_ID,
   output logic            Busy2_ID
);

   logic [XLEN-1:0]  regs [NHARTS][NREGS];
   logic [NREGS-1:0] busy [NHARTS];

   logic wb_en;
   logic set_en;
   logic byp1;
   logic byp2;

   assign wb_en  = RegWrite_ee && (Waddr_ee != '0);
   assign set_en = IssueWr_ID && (Waddr_ID != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the register array is reset flop-by-flop on purpose; every hart must start from all-zero state.
         for (int h = 0; h < NHARTS; h++) begin
            busy[h] <= '0;
            for (int r = 0; r < NREGS; r++) begin
               regs[h][r] <= '0;
            end
         end
      end else begin
         if (wb_en) begin
            regs[mhartID_ee][Waddr_ee] <= Wdata_ee;
            busy[mhartID_ee][Waddr_ee] <= 1'b0;
         end
         // NOTE: the set is scheduled after the clear so the last non-blocking update wins on a collision.
         if (set_en) begin
            busy[mhartID_ID][Waddr_ID] <= 1'b1;
         end
      end
   end

   // x0 is never written and never set busy, so its stored value and busy bit stay 0.
   assign byp1 = wb_en && (mhartID_ee == mhartID_ID) && (Waddr_ee == Raddr1_ID);
   assign byp2 = wb_en && (mhartID_ee == mhartID_ID) && (Waddr_ee == Raddr2_ID);

   assign Rdata1_ID = byp1 ? Wdata_ee : regs[mhartID_ID][Raddr1_ID];
   assign Rdata2_ID = byp2 ? Wdata_ee : regs[mhartID_ID][Raddr2_ID];

   assign Busy1_ID = busy[mhartID_ID][Raddr1_ID] && !byp1 && (Raddr1_ID != '0);
   assign Busy2_ID = busy[mhartID_ID][Raddr2_ID] && !byp2 && (Raddr2_ID != '0);

endmodule

// File: tb/tb_hart_regfile.sv
// Self-checking bench for hart_regfile: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an array-based model.
module tb_hart_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWrite_ee;
   logic [4:0]  Waddr_ee;
   logic [31:0] Wdata_ee;
   logic [1:0]  mhartID_ee;
   logic [1:0]  mhartID_ID;
   logic [4:0]  Raddr1_ID;
   logic [4:0]  Raddr2_ID;
   logic [31:0] Rdata1_ID;
   logic [31:0] Rdata2_ID;
   logic        IssueWr_ID;
   logic [4:0]  Waddr_ID;
   logic        Busy1_ID;
   logic        Busy2_ID;

   int n_tests = 0;
   int n_fail  = 0;

   hart_regfile dut (
      .clk        (clk),
      .rst        (rst),
      .RegWrite_ee(RegWrite_ee),
      .Waddr_ee   (Waddr_ee),
      .Wdata_ee   (Wdata_ee),
      .mhartID_ee (mhartID_ee),
      .mhartID_ID (mhartID_ID),
      .Raddr1_ID  (Raddr1_ID),
      .Raddr2_ID  (Raddr2_ID),
      .Rdata1_ID  (Rdata1_ID),
      .Rdata2_ID  (Rdata2_ID),
      .IssueWr_ID (IssueWr_ID),
      .Waddr_ID   (Waddr_ID),
      .Busy1_ID   (Busy1_ID),
      .Busy2_ID   (Busy2_ID)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural model: plain arrays indexed by hart and register.
   logic [31:0] m_regs [4][32];
   bit          m_busy [4][32];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int h = 0; h < 4; h++)
            for (int r = 0; r < 32; r++) begin
               m_regs[h][r] = 32'h0;
               m_busy[h][r] = 1'b0;
            end
      end else begin
         if (RegWrite_ee && Waddr_ee != 0) begin
            m_regs[mhartID_ee][Waddr_ee] = Wdata_ee;
            m_busy[mhartID_ee][Waddr_ee] = 1'b0;
         end
         if (IssueWr_ID && Waddr_ID != 0)
            m_busy[mhartID_ID][Waddr_ID] = 1'b1;
      end
   end

   function automatic bit fwd(input logic [4:0] a);
      return RegWrite_ee && a != 0 && Waddr_ee == a && mhartID_ee == mhartID_ID;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (fwd(a)) return Wdata_ee;
      return m_regs[mhartID_ID][a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (a == 0 || fwd(a)) return 1'b0;
      return m_busy[mhartID_ID][a];
   endfunction

   // Every-cycle compare, mid-cycle when inputs and state are stable.
   always @(negedge clk) begin
      check("rdata1", Rdata1_ID, exp_rd(Raddr1_ID));
      check("rdata2", Rdata2_ID, exp_rd(Raddr2_ID));
      check("busy1", {31'b0, Busy1_ID}, {31'b0, exp_busy(Raddr1_ID)});
      check("busy2", {31'b0, Busy2_ID}, {31'b0, exp_busy(Raddr2_ID)});
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      RegWrite_ee = 1'b0;
      IssueWr_ID  = 1'b0;
   endtask

   task automatic wb(input logic [1:0] h, input logic [4:0] a, input logic [31:0] d);
      RegWrite_ee = 1'b1;
      mhartID_ee  = h;
      Waddr_ee    = a;
      Wdata_ee    = d;
   endtask

   task automatic issue(input logic [1:0] h, input logic [4:0] a);
      IssueWr_ID = 1'b1;
      mhartID_ID = h;
      Waddr_ID   = a;
   endtask

   task automatic rd(input logic [1:0] h, input logic [4:0] a1, input logic [4:0] a2);
      mhartID_ID = h;
      Raddr1_ID  = a1;
      Raddr2_ID  = a2;
      #1;
   endtask

   function automatic logic [4:0] pick_addr();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 5));
   endfunction

   initial begin
      rst = 1'b1;
      idle();
      Waddr_ee = 0; Wdata_ee = 0; mhartID_ee = 0;
      mhartID_ID = 0; Raddr1_ID = 0; Raddr2_ID = 0; Waddr_ID = 0;
      cyc();
      rd(1, 5, 6);
      check("reset_rdata", Rdata1_ID, 32'h0);
      check("reset_busy", {31'b0, Busy2_ID}, 32'h0);
      cyc();
      rst = 1'b0;

      // Reset mid-run clears data and busy immediately and afterwards.
      wb(1, 5, 32'hDEADBEEF); cyc(); idle();
      issue(1, 6); cyc(); idle();
      rd(1, 5, 6);
      check("pre_rst_data", Rdata1_ID, 32'hDEADBEEF);
      check("pre_rst_busy", {31'b0, Busy2_ID}, 32'h1);
      rst = 1'b1; #1;
      check("async_rst_data", Rdata1_ID, 32'h0);
      check("async_rst_busy", {31'b0, Busy2_ID}, 32'h0);
      cyc(); cyc();
      rst = 1'b0;
      cyc();
      check("post_rst_data", Rdata1_ID, 32'h0);
      check("post_rst_busy", {31'b0, Busy2_ID}, 32'h0);

      // Bank isolation.
      wb(0, 3, 32'h11111111); cyc();
      wb(2, 3, 32'h22222222); cyc(); idle();
      rd(0, 3, 3); check("bank_h0", Rdata1_ID, 32'h11111111);
      rd(2, 3, 3); check("bank_h2", Rdata2_ID, 32'h22222222);
      rd(1, 3, 3); check("bank_h1", Rdata1_ID, 32'h0);

      // x0 is hardwired zero and never busy.
      wb(2, 0, 32'hFFFFFFFF); issue(2, 0); rd(2, 0, 0);
      check("x0_same_cycle", Rdata1_ID, 32'h0);
      cyc(); idle(); #1;
      check("x0_rdata", Rdata2_ID, 32'h0);
      check("x0_busy", {30'b0, Busy1_ID, Busy2_ID}, 32'h0);

      // Same-hart bypass, and no bypass across harts.
      wb(1, 7, 32'hC); cyc();
      wb(3, 7, 32'hA); cyc();
      wb(3, 7, 32'hB); rd(3, 7, 7);
      check("bypass_p1", Rdata1_ID, 32'hB);
      check("bypass_p2", Rdata2_ID, 32'hB);
      check("bypass_busy", {30'b0, Busy1_ID, Busy2_ID}, 32'h0);
      rd(1, 7, 7);
      check("no_xhart_bypass", Rdata1_ID, 32'hC);
      cyc(); idle();

      // Scoreboard set, per-hart view, and clear with bypass.
      issue(2, 9); cyc(); idle();
      rd(2, 9, 0); check("sb_set", {31'b0, Busy1_ID}, 32'h1);
      rd(0, 9, 0); check("sb_other_hart", {31'b0, Busy1_ID}, 32'h0);
      wb(2, 9, 32'h55); rd(2, 9, 9);
      check("sb_clear_busy", {31'b0, Busy1_ID}, 32'h0);
      check("sb_clear_data", Rdata1_ID, 32'h55);
      cyc(); idle(); #1;
      check("sb_cleared", {31'b0, Busy1_ID}, 32'h0);
      check("sb_stored", Rdata1_ID, 32'h55);

      // Set and clear collide: set wins, data still stored.
      issue(1, 4); wb(1, 4, 32'h77); cyc(); idle();
      rd(1, 4, 4);
      check("coll_data", Rdata1_ID, 32'h77);
      check("coll_busy", {31'b0, Busy1_ID}, 32'h1);
      issue(1, 6); wb(1, 4, 32'h78); cyc(); idle();
      issue(1, 4); wb(1, 6, 32'h66); cyc(); idle();
      rd(1, 4, 6);
      check("diff_set", {31'b0, Busy1_ID}, 32'h1);
      check("diff_clear", {31'b0, Busy2_ID}, 32'h0);
      check("diff_data", Rdata2_ID, 32'h66);

      // Randomized traffic; the negedge process compares every cycle.
      for (int i = 0; i < 4000; i++) begin
         RegWrite_ee = 1'($urandom_range(0, 1));
         Waddr_ee    = pick_addr();
         Wdata_ee    = $urandom;
         mhartID_ee  = 2'($urandom_range(0, 3));
         mhartID_ID  = ($urandom_range(0, 2) == 0) ? mhartID_ee : 2'($urandom_range(0, 3));
         Raddr1_ID   = pick_addr();
         Raddr2_ID   = ($urandom_range(0, 3) == 0) ? Waddr_ee : pick_addr();
         IssueWr_ID  = 1'($urandom_range(0, 1));
         Waddr_ID    = ($urandom_range(0, 4) == 0) ? Waddr_ee : pick_addr();
         if ($urandom_range(0, 999) == 0) begin
            rst = 1'b1; #1; rst = 1'b0;
         end
         cyc();
      end
      idle();
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hart_regfile.md
Name: hart_regfile

Overview:
Per-hart banked integer register file with a per-register pending-write scoreboard. It sits directly downstream of the writeback stage and consumes its Wdata_ee/Waddr_ee/RegWrite_ee/mhartID_ee write port. It also serves two combinational read ports plus busy flags to the decode stage of the same hart-interleaved pipeline. Each hart sees an independent x0..x31 architectural set.

Parameters:
NHARTS, 4, number of hardware threads (banks); hart ID width is log2(NHARTS) = 2.
XLEN, 32, register data width.
NREGS, 32, registers per hart; address width is 5.

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
RegWrite_ee  input  1  writeback write enable
Waddr_ee  input  5  writeback destination register
Wdata_ee  input  32  writeback data
mhartID_ee  input  2  hart owning the writeback
mhartID_ID  input  2  hart currently in decode
Raddr1_ID  input  5  source register 1 address
Raddr2_ID  input  5  source register 2 address
Rdata1_ID  output  32  source 1 data
Rdata2_ID  output  32  source 2 data
IssueWr_ID  input  1  decode issues an instruction that will write Waddr_ID (set busy)
Waddr_ID  input  5  destination of the issuing instruction
Busy1_ID  output  1  source 1 has a pending, not-yet-written result
Busy2_ID  output  1  source 2 has a pending, not-yet-written result

Behaviour:
- Storage: NHARTS x NREGS x XLEN flops. Busy: NHARTS x NREGS bits.
- Reset (async, rst=1): all registers of all harts = 0. All busy bits = 0. Held while rst asserted. Reset mid-operation discards any in-flight write or set that cycle.
- Write: on rising clk, if RegWrite_ee=1 and Waddr_ee!=0, then reg[mhartID_ee][Waddr_ee] <= Wdata_ee. Writes to x0 are dropped. Only the addressed hart's bank changes.
- x0: always reads 0 and is never busy. Busy bit 0 of every hart is never set.
- Read: combinational, zero latency. RdataN_ID = reg[mhartID_ID][RaddrN_ID], with write-through bypass:
  - Bypass condition: RegWrite_ee=1 and mhartID_ee==mhartID_ID and Waddr_ee==RaddrN_ID and RaddrN_ID!=0.
  - When it holds, RdataN_ID = Wdata_ee (same-cycle write visible).
  - No bypass across harts: a different hart ID reads the stored value.
- Scoreboard:
  - Set: on clk, if IssueWr_ID=1 and Waddr_ID!=0, busy[mhartID_ID][Waddr_ID] <= 1.
  - Clear: on clk, if RegWrite_ee=1 and Waddr_ee!=0, busy[mhartID_ee][Waddr_ee] <= 0.
  - Same hart and register set and cleared in the same cycle: set wins, so the bit ends 1 (the newer instruction owns it).
  - Different targets: both updates apply.
  - RegWrite_ee to a non-busy register: still writes data; busy stays 0.
- Busy outputs:
  - BusyN_ID = busy[mhartID_ID][RaddrN_ID] AND NOT (bypass condition for port N) AND (RaddrN_ID!=0).
  - A result arriving this cycle therefore reports not-busy, with its data on RdataN_ID.
  - An IssueWr_ID set in the current cycle does not affect the same cycle's BusyN_ID.
- Both read ports may address the same register; each independently applies bypass and busy.
- No X propagation: all outputs are defined for all input values after reset.

Test Plan:
- Reset: assert rst mid-run after writing hart1 x5=0xDEADBEEF -> all reads return 0 and all busy=0, immediately (async), and remain so after deassert.
- Bank isolation: write hart0 x3=0x11111111, hart2 x3=0x22222222 -> reading x3 with mhartID_ID=0 gives 0x11111111, with 2 gives 0x22222222, with 1 gives 0.
- x0: RegWrite_ee=1, Waddr_ee=0, Wdata_ee=0xFFFFFFFF, and IssueWr_ID to x0 -> Rdata=0 and Busy=0 on both ports, next cycle and later.
- Bypass: hart3 x7 holds 0xA; same cycle RegWrite_ee hart3 x7=0xB, decode hart3 reads x7 on both ports -> Rdata1/2=0xB, Busy=0. The same write with decode on hart1 -> hart1's stored x7 returned.
- Scoreboard: IssueWr_ID hart2 x9 -> next cycle Busy1 on x9 (hart2) = 1, hart0 x9 busy = 0. WB writes hart2 x9=0x55 -> that cycle Busy1=0 and Rdata1=0x55; bit cleared afterward.
- Simultaneous set/clear: same cycle IssueWr_ID hart1 x4 and RegWrite_ee hart1 x4=0x77 -> data stored 0x77, busy[1][4]=1 next cycle. Set hart1 x4 with clear hart1 x6 -> x4 busy=1, x6 busy=0.
